// File: rtl/alu_seq_pkg.sv
// Shared types and PS/2 set-2 scan-code constants for the ALU key sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    AND = 3'd3,
    OR  = 3'd4,
    XOR = 3'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    SHOW    = 3'd4,
    ERR     = 3'd5
  } state_e;

  localparam logic [7:0] KC_D0 = 8'h45;
  localparam logic [7:0] KC_D1 = 8'h16;
  localparam logic [7:0] KC_D2 = 8'h1E;
  localparam logic [7:0] KC_D3 = 8'h26;
  localparam logic [7:0] KC_D4 = 8'h25;
  localparam logic [7:0] KC_D5 = 8'h2E;
  localparam logic [7:0] KC_D6 = 8'h36;
  localparam logic [7:0] KC_D7 = 8'h3D;
  localparam logic [7:0] KC_D8 = 8'h3E;
  localparam logic [7:0] KC_D9 = 8'h46;

  localparam logic [7:0] KC_ADD = 8'h79;
  localparam logic [7:0] KC_SUB = 8'h7B;
  localparam logic [7:0] KC_MUL = 8'h7C;
  localparam logic [7:0] KC_AND = 8'h1C;
  localparam logic [7:0] KC_OR  = 8'h44;
  localparam logic [7:0] KC_XOR = 8'h22;

  localparam logic [7:0] KC_BREAK = 8'hF0;
  localparam logic [7:0] KC_EXT   = 8'hE0;
  localparam logic [7:0] KC_ENTER = 8'h5A;
  localparam logic [7:0] KC_ESC   = 8'h76;

  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_RES = 2'd2;
  localparam logic [1:0] SEL_ERR = 2'd3;

endpackage

// File: rtl/ps2_key_decode.sv
// Combinational classifier: one scan-code byte -> digit / operator / Enter / Esc.
module ps2_key_decode
  import alu_seq_pkg::*;
(
  input  logic [7:0] code,
  output logic       is_digit_c,
  output logic [3:0] digit_c,
  output logic       is_op_c,
  output alu_op_e    op_c,
  output logic       is_enter_c,
  output logic       is_esc_c
);

  always_comb begin
    is_digit_c = 1'b0;
    digit_c    = 4'd0;
    is_op_c    = 1'b0;
    op_c       = ADD;
    is_enter_c = (code == KC_ENTER);
    is_esc_c   = (code == KC_ESC);
    case (code)
      KC_D0:   begin is_digit_c = 1'b1; digit_c = 4'd0; end
      KC_D1:   begin is_digit_c = 1'b1; digit_c = 4'd1; end
      KC_D2:   begin is_digit_c = 1'b1; digit_c = 4'd2; end
      KC_D3:   begin is_digit_c = 1'b1; digit_c = 4'd3; end
      KC_D4:   begin is_digit_c = 1'b1; digit_c = 4'd4; end
      KC_D5:   begin is_digit_c = 1'b1; digit_c = 4'd5; end
      KC_D6:   begin is_digit_c = 1'b1; digit_c = 4'd6; end
      KC_D7:   begin is_digit_c = 1'b1; digit_c = 4'd7; end
      KC_D8:   begin is_digit_c = 1'b1; digit_c = 4'd8; end
      KC_D9:   begin is_digit_c = 1'b1; digit_c = 4'd9; end
      KC_ADD:  begin is_op_c = 1'b1; op_c = ADD; end
      KC_SUB:  begin is_op_c = 1'b1; op_c = SUB; end
      KC_MUL:  begin is_op_c = 1'b1; op_c = MUL; end
      KC_AND:  begin is_op_c = 1'b1; op_c = AND; end
      KC_OR:   begin is_op_c = 1'b1; op_c = OR;  end
      KC_XOR:  begin is_op_c = 1'b1; op_c = XOR; end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_key_sequencer.sv
// PS/2 keypad to ALU sequencer: builds A op B, runs one req/ack transaction, drives the display.
// Optional build macro ALU_SEQ_CHAIN_EN: an operator in SHOW chains the result into A.
module alu_key_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kb_valid,
  input  logic [7:0]        kb_code,
  output logic              alu_req,
  output alu_op_e           alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_ack,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_err,
  output logic [DATA_W-1:0] disp_val,
  output logic [1:0]        disp_sel,
  output logic              busy
);

  localparam int unsigned ACC_W = DATA_W + 4;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e             state, state_d;
  logic [DATA_W-1:0]  a_d, b_d, disp_val_d;
  alu_op_e            op_d;
  logic [1:0]         disp_sel_d;
  logic               bdig, bdig_d;
  logic               brk, brk_d;
  logic               ext, ext_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               req_d;

  logic               key_c;
  logic               is_digit_c, is_op_c, is_enter_c, is_esc_c;
  logic [3:0]         dig_c;
  alu_op_e            dec_op_c;
  logic [DATA_W-1:0]  acc_src_c;
  logic [ACC_W-1:0]   acc_c;
  logic               acc_ok_c;
  logic [DATA_W-1:0]  acc_lo_c;

  ps2_key_decode u_dec (
    .code       (kb_code),
    .is_digit_c (is_digit_c),
    .digit_c    (dig_c),
    .is_op_c    (is_op_c),
    .op_c       (dec_op_c),
    .is_enter_c (is_enter_c),
    .is_esc_c   (is_esc_c)
  );

  // Decimal shift-in; the upper nibble of the wide sum flags overflow of DATA_W.
  always_comb begin
    acc_src_c = (state == ENTER_B) ? alu_b : alu_a;
    acc_c     = ACC_W'(acc_src_c) * ACC_W'(10) + ACC_W'(dig_c);
    acc_ok_c  = (acc_c[ACC_W-1:DATA_W] == '0);
    acc_lo_c  = acc_c[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ENTER_A;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= ADD;
      bdig     <= 1'b0;
      brk      <= 1'b0;
      ext      <= 1'b0;
      cnt      <= '0;
      alu_req  <= 1'b0;
      busy     <= 1'b0;
      disp_val <= '0;
      disp_sel <= SEL_A;
    end else begin
      state    <= state_d;
      alu_a    <= a_d;
      alu_b    <= b_d;
      alu_op   <= op_d;
      bdig     <= bdig_d;
      brk      <= brk_d;
      ext      <= ext_d;
      cnt      <= cnt_d;
      alu_req  <= req_d;
      busy     <= req_d;
      disp_val <= disp_val_d;
      disp_sel <= disp_sel_d;
    end
  end

  always_comb begin
    state_d    = state;
    a_d        = alu_a;
    b_d        = alu_b;
    op_d       = alu_op;
    bdig_d     = bdig;
    brk_d      = brk;
    ext_d      = ext;
    cnt_d      = cnt;
    disp_val_d = disp_val;
    disp_sel_d = disp_sel;
    key_c      = 1'b0;

    // Prefix tracking runs in every state; a byte after F0 is swallowed.
    if (kb_valid) begin
      if (brk) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (kb_code == KC_BREAK) begin
        brk_d = 1'b1;
      end else if (kb_code == KC_EXT) begin
        ext_d = 1'b1;
      end else begin
        key_c = 1'b1;
        ext_d = 1'b0;
      end
    end

    case (state)
      ENTER_A: begin
        if (key_c) begin
          if (is_digit_c) begin
            if (acc_ok_c) a_d = acc_lo_c;
            disp_val_d = a_d;
            disp_sel_d = SEL_A;
          end else if (is_op_c) begin
            op_d       = dec_op_c;
            b_d        = '0;
            bdig_d     = 1'b0;
            disp_val_d = '0;
            disp_sel_d = SEL_B;
            state_d    = ENTER_B;
          end else if (is_esc_c) begin
            a_d        = '0;
            disp_val_d = '0;
            disp_sel_d = SEL_A;
          end
        end
      end

      ENTER_B: begin
        if (key_c) begin
          if (is_digit_c) begin
            if (acc_ok_c) b_d = acc_lo_c;
            bdig_d     = 1'b1;
            disp_val_d = b_d;
            disp_sel_d = SEL_B;
          end else if (is_op_c) begin
            if (!bdig) op_d = dec_op_c;
          end else if (is_enter_c) begin
            state_d = ISSUE;
          end else if (is_esc_c) begin
            a_d        = '0;
            b_d        = '0;
            disp_val_d = '0;
            disp_sel_d = SEL_A;
            state_d    = ENTER_A;
          end
        end
      end

      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      // Ack has priority over the timeout in the same cycle.
      WAIT: begin
        if (alu_ack) begin
          if (alu_err) begin
            disp_val_d = '0;
            disp_sel_d = SEL_ERR;
            state_d    = ERR;
          end else begin
            disp_val_d = alu_result;
            disp_sel_d = SEL_RES;
            state_d    = SHOW;
          end
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          disp_val_d = '0;
          disp_sel_d = SEL_ERR;
          state_d    = ERR;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      SHOW: begin
        if (key_c) begin
          if (is_digit_c) begin
            a_d        = DATA_W'(dig_c);
            b_d        = '0;
            disp_val_d = DATA_W'(dig_c);
            disp_sel_d = SEL_A;
            state_d    = ENTER_A;
          end else if (is_esc_c) begin
            a_d        = '0;
            b_d        = '0;
            disp_val_d = '0;
            disp_sel_d = SEL_A;
            state_d    = ENTER_A;
          end
`ifdef ALU_SEQ_CHAIN_EN
          else if (is_op_c) begin
            a_d        = disp_val;
            op_d       = dec_op_c;
            b_d        = '0;
            bdig_d     = 1'b0;
            disp_val_d = '0;
            disp_sel_d = SEL_B;
            state_d    = ENTER_B;
          end
`else
          else begin
            // Operators and Enter leave the result on display.
          end
`endif
        end
      end

      ERR: begin
        if (key_c && is_esc_c) begin
          a_d        = '0;
          b_d        = '0;
          disp_val_d = '0;
          disp_sel_d = SEL_A;
          state_d    = ENTER_A;
        end
      end

      default: state_d = ENTER_A;
    endcase

    req_d = (state_d == ISSUE) || (state_d == WAIT);
  end

endmodule

// File: tb/tb_alu_key_sequencer.sv
// Directed self-checking bench for alu_key_sequencer (DATA_W=16, TIMEOUT_CYC=100).
module tb_alu_key_sequencer;
  import alu_seq_pkg::*;

  logic        clk;
  logic        reset;
  logic        kb_valid;
  logic [7:0]  kb_code;
  logic        alu_req;
  alu_op_e     alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_ack;
  logic [15:0] alu_result;
  logic        alu_err;
  logic [15:0] disp_val;
  logic [1:0]  disp_sel;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  alu_key_sequencer #(.DATA_W(16), .TIMEOUT_CYC(100)) dut (
    .clk        (clk),
    .reset      (reset),
    .kb_valid   (kb_valid),
    .kb_code    (kb_code),
    .alu_req    (alu_req),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ack    (alu_ack),
    .alu_result (alu_result),
    .alu_err    (alu_err),
    .disp_val   (disp_val),
    .disp_sel   (disp_sel),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Present one byte for a single cycle; returns 1 ns after the sampling edge.
  task automatic send(input logic [7:0] code);
    kb_valid = 1'b1;
    kb_code  = code;
    @(posedge clk); #1;
    kb_valid = 1'b0;
    kb_code  = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ack_pulse(input logic [15:0] res, input logic err);
    alu_ack    = 1'b1;
    alu_result = res;
    alu_err    = err;
    tick();
    alu_ack    = 1'b0;
    alu_err    = 1'b0;
  endtask

  initial begin
    kb_valid = 1'b0; kb_code = 8'h00; alu_ack = 1'b0; alu_result = 16'h0; alu_err = 1'b0;
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(alu_req), 32'd0);
    check("rst_op", 32'(alu_op), 32'd0);
    check("rst_a", 32'(alu_a), 32'd0);
    check("rst_b", 32'(alu_b), 32'd0);
    check("rst_val", 32'(disp_val), 32'd0);
    check("rst_sel", 32'(disp_sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    // 12 + 34 with ack three cycles after req
    send(8'h16); check("t1_val1", 32'(disp_val), 32'd1);
    send(8'h1E); check("t1_val12", 32'(disp_val), 32'd12);
    send(8'h79); check("t1_selb", 32'(disp_sel), 32'd1);
    check("t1_valb0", 32'(disp_val), 32'd0);
    send(8'h26); send(8'h25); check("t1_val34", 32'(disp_val), 32'd34);
    send(8'h5A);
    check("t1_req0", 32'(alu_req), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_a", 32'(alu_a), 32'd12);
    check("t1_b", 32'(alu_b), 32'd34);
    check("t1_op", 32'(alu_op), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("t1_req%0d", i), 32'(alu_req), 32'd1);
    end
    check("t1_a_hold", 32'(alu_a), 32'd12);
    check("t1_b_hold", 32'(alu_b), 32'd34);
    ack_pulse(16'd46, 1'b0);
    check("t1_req_drop", 32'(alu_req), 32'd0);
    check("t1_busy_drop", 32'(busy), 32'd0);
    check("t1_sel", 32'(disp_sel), 32'd2);
    check("t1_res", 32'(disp_val), 32'd46);
    send(8'h5A); check("t1_enter_show", 32'(disp_sel), 32'd2);
    send(8'h76); check("t1_esc_sel", 32'(disp_sel), 32'd0);
    check("t1_esc_val", 32'(disp_val), 32'd0);

    // break byte discarded, keypad Enter ignored in ENTER_A
    send(8'h16); send(8'hF0); send(8'h16); send(8'hE0); send(8'h5A);
    check("t2_a", 32'(alu_a), 32'd1);
    check("t2_val", 32'(disp_val), 32'd1);
    check("t2_sel", 32'(disp_sel), 32'd0);
    check("t2_req", 32'(alu_req), 32'd0);
    send(8'h79); check("t2_still_a", 32'(disp_sel), 32'd1);
    send(8'h76); check("t2_esc_a", 32'(alu_a), 32'd0);

    // overflow boundary at 65535
    send(8'h36); check("t3_6", 32'(disp_val), 32'd6);
    send(8'h2E); check("t3_65", 32'(disp_val), 32'd65);
    send(8'h2E); check("t3_655", 32'(disp_val), 32'd655);
    send(8'h26); check("t3_6553", 32'(disp_val), 32'd6553);
    send(8'h36); check("t3_drop", 32'(disp_val), 32'd6553);
    check("t3_a", 32'(alu_a), 32'd6553);
    send(8'h76);

    // op replace before B digits, ignored after; then timeout
    send(8'h16); send(8'h79); send(8'h7B); send(8'h1E); send(8'h7C); send(8'h5A);
    check("t4_op_sub", 32'(alu_op), 32'd1);
    check("t4_req", 32'(alu_req), 32'd1);
    send(8'h76);
    check("t4_esc_drop", 32'(busy), 32'd1);
    check("t4_a_kept", 32'(alu_a), 32'd1);
    repeat (99) tick();
    check("t4_req_last", 32'(alu_req), 32'd1);
    tick();
    check("t4_req_to", 32'(alu_req), 32'd0);
    check("t4_sel_err", 32'(disp_sel), 32'd3);
    check("t4_val_err", 32'(disp_val), 32'd0);
    send(8'h16); check("t4_key_ign", 32'(disp_sel), 32'd3);
    send(8'h76);
    check("t4_esc_sel", 32'(disp_sel), 32'd0);
    check("t4_esc_val", 32'(disp_val), 32'd0);

    // ALU error path
    send(8'h16); send(8'h7B); send(8'h1E); send(8'h5A); tick();
    ack_pulse(16'hFFFF, 1'b1);
    check("t5_sel_err", 32'(disp_sel), 32'd3);
    check("t5_val", 32'(disp_val), 32'd0);
    check("t5_req", 32'(alu_req), 32'd0);
    send(8'h76);

    // async reset mid-WAIT, then a late ack
    send(8'h1E); send(8'h79); send(8'h26); send(8'h5A); tick();
    check("t6_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("t6_req_async", 32'(alu_req), 32'd0);
    check("t6_a_async", 32'(alu_a), 32'd0);
    tick();
    check("t6_busy_rst", 32'(busy), 32'd0);
    check("t6_b_rst", 32'(alu_b), 32'd0);
    reset = 1'b0;
    ack_pulse(16'd99, 1'b0);
    check("t6_late_ack_sel", 32'(disp_sel), 32'd0);
    check("t6_late_ack_val", 32'(disp_val), 32'd0);
    check("t6_late_ack_req", 32'(alu_req), 32'd0);

    // 2 * 3, then operator in SHOW
    send(8'h1E); send(8'h7C); send(8'h26); send(8'h5A);
    check("t7_op_mul", 32'(alu_op), 32'd2);
    check("t7_a", 32'(alu_a), 32'd2);
    check("t7_b", 32'(alu_b), 32'd3);
    tick();
    ack_pulse(16'd6, 1'b0);
    check("t7_res", 32'(disp_val), 32'd6);
    send(8'h79);
`ifdef ALU_SEQ_CHAIN_EN
    check("t7_chain_sel", 32'(disp_sel), 32'd1);
    check("t7_chain_a", 32'(alu_a), 32'd6);
    send(8'h25); send(8'h5A);
    check("t7_chain_req", 32'(alu_req), 32'd1);
    check("t7_chain_a2", 32'(alu_a), 32'd6);
    check("t7_chain_b2", 32'(alu_b), 32'd4);
    check("t7_chain_op", 32'(alu_op), 32'd0);
    tick();
    ack_pulse(16'd10, 1'b0);
    check("t7_chain_res", 32'(disp_val), 32'd10);
`else
    check("t7_op_ign_sel", 32'(disp_sel), 32'd2);
    check("t7_op_ign_val", 32'(disp_val), 32'd6);
    send(8'h25);
    check("t7_new_sel", 32'(disp_sel), 32'd0);
    check("t7_new_val", 32'(disp_val), 32'd4);
    check("t7_new_a", 32'(alu_a), 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
